// File: rtl/cat_pkg.sv
// Shared definitions for the CatRecognizer frame loader: frame FSM encoding
// and the fixed register map of the CatRecognizer APB slave.
package cat_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        SETUP  = 3'd2,
        ACCESS = 3'd3,
        WAIT   = 3'd4
    } state_t;

    localparam int START_REG_ADDR = 0;
    localparam int PIX_BASE_ADDR  = 1;
    localparam int START_CMD      = 1;

endpackage

// File: rtl/apb_master_if.sv
// APB write-phase sequencer: decodes SETUP/ACCESS phase strobes into the bus
// controls and holds PADDR/PWDATA stable across the whole transfer.
module apb_master_if #(
    parameter int Amba_Word       = 24,
    parameter int Amba_Addr_Depth = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load_en,
    input  logic [Amba_Addr_Depth:0]   load_addr,
    input  logic [Amba_Word-1:0]       load_data,
    input  logic                       phase_setup,
    input  logic                       phase_access,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [Amba_Addr_Depth:0]   PADDR,
    output logic [Amba_Word-1:0]       PWDATA
);

    logic [Amba_Addr_Depth:0] paddr_q, paddr_d;
    logic [Amba_Word-1:0]     pwdata_q, pwdata_d;

    // Address/data only move while the bus is idle, so they are stable from
    // SETUP through ACCESS by construction.
    always_comb begin
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        if (load_en) begin
            paddr_d  = load_addr;
            pwdata_d = load_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            paddr_q  <= '0;
            pwdata_q <= '0;
        end else begin
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
        end
    end

    // Phase strobes come straight from reset-cleared state flops, so the
    // bus controls fall as soon as reset asserts.
    assign PSEL    = phase_setup | phase_access;
    assign PENABLE = phase_access;
    assign PWRITE  = phase_setup | phase_access;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;

endmodule

// File: rtl/apb_frame_loader.sv
// Streams one frame of pixel words into the CatRecognizer over APB, kicks the
// start register, waits a fixed latency and captures the classification.
//
// state  | meaning
// IDLE   | no frame; waiting for start
// FETCH  | pix_ready high, waiting for the next pixel word
// SETUP  | APB setup phase (pixel or start-register write)
// ACCESS | APB access phase; decide next word / start write / wait
// WAIT   | result latency countdown, then sample cat_in
module apb_frame_loader
    import cat_pkg::*;
#(
    parameter int Amba_Word       = 24,
    parameter int Amba_Addr_Depth = 12,
    parameter int NumWords        = 4096,
    parameter int ResultLatency   = 4200
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       pix_valid,
    input  logic [Amba_Word-1:0]       pix_data,
    output logic                       pix_ready,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [Amba_Addr_Depth:0]   PADDR,
    output logic [Amba_Word-1:0]       PWDATA,
    input  logic                       cat_in,
    output logic                       busy,
    output logic                       done,
    output logic                       cat_result
);

    localparam int AddrW = Amba_Addr_Depth + 1;
    localparam int CntW  = $clog2(NumWords + 1);
    localparam int TmrW  = $clog2(ResultLatency + 1);

    localparam logic [CntW-1:0]      CNT_LAST  = CntW'(NumWords);
    localparam logic [TmrW-1:0]      TMR_LOAD  = TmrW'(ResultLatency - 1);
    localparam logic [AddrW-1:0]     ADDR_BASE = AddrW'(PIX_BASE_ADDR);
    localparam logic [AddrW-1:0]     ADDR_GO   = AddrW'(START_REG_ADDR);
    localparam logic [Amba_Word-1:0] DATA_GO   = Amba_Word'(START_CMD);

    state_t            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [TmrW-1:0]   tmr_q, tmr_d;
    logic              start_phase_q, start_phase_d;
    logic              done_q, done_d;
    logic              res_q, res_d;

    logic              ld_en;
    logic [AddrW-1:0]  ld_addr;
    logic [Amba_Word-1:0] ld_data;

    assign cnt_inc = cnt_q + CntW'(1);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tmr_d         = tmr_q;
        start_phase_d = start_phase_q;
        done_d        = 1'b0;
        res_d         = res_q;
        ld_en         = 1'b0;
        ld_addr       = '0;
        ld_data       = '0;

        case (state_q)
            IDLE: begin
                // done_q high means we are in the result cycle; a start there
                // is deliberately dropped.
                if (start && !done_q) begin
                    state_d       = FETCH;
                    cnt_d         = '0;
                    start_phase_d = 1'b0;
                end
            end
            FETCH: begin
                if (pix_valid) begin
                    ld_en   = 1'b1;
                    ld_addr = AddrW'(cnt_q) + ADDR_BASE;
                    ld_data = pix_data;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (start_phase_q) begin
                    tmr_d   = TMR_LOAD;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc < CNT_LAST) begin
                        state_d = FETCH;
                    end else begin
                        ld_en         = 1'b1;
                        ld_addr       = ADDR_GO;
                        ld_data       = DATA_GO;
                        start_phase_d = 1'b1;
                        state_d       = SETUP;
                    end
                end
            end
            WAIT: begin
                if (tmr_q == '0) begin
                    res_d   = cat_in;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - TmrW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            tmr_q         <= '0;
            start_phase_q <= 1'b0;
            done_q        <= 1'b0;
            res_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tmr_q         <= tmr_d;
            start_phase_q <= start_phase_d;
            done_q        <= done_d;
            res_q         <= res_d;
        end
    end

    apb_master_if #(
        .Amba_Word       (Amba_Word),
        .Amba_Addr_Depth (Amba_Addr_Depth)
    ) u_apb (
        .clk          (clk),
        .rst          (rst),
        .load_en      (ld_en),
        .load_addr    (ld_addr),
        .load_data    (ld_data),
        .phase_setup  (state_q == SETUP),
        .phase_access (state_q == ACCESS),
        .PSEL         (PSEL),
        .PENABLE      (PENABLE),
        .PWRITE       (PWRITE),
        .PADDR        (PADDR),
        .PWDATA       (PWDATA)
    );

    assign pix_ready  = (state_q == FETCH);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign cat_result = res_q;

endmodule

// File: tb/tb_apb_frame_loader.sv
// Bench for apb_frame_loader: transaction-level model of the frame (expected
// APB writes, result timing, busy/done) checked every cycle on the falling edge.
module tb_apb_frame_loader;

    localparam int W   = 24;
    localparam int AD  = 12;
    localparam int N   = 4096;
    localparam int RL  = 4200;
    localparam int LAT = 16491;   // 3*4096 + 3 + 4200

    logic          clk;
    logic          rst;
    logic          start;
    logic          pix_valid;
    logic [W-1:0]  pix_data;
    logic          pix_ready;
    logic          PSEL, PENABLE, PWRITE;
    logic [AD:0]   PADDR;
    logic [W-1:0]  PWDATA;
    logic          cat_in;
    logic          busy, done, cat_result;

    apb_frame_loader #(
        .Amba_Word(W), .Amba_Addr_Depth(AD), .NumWords(N), .ResultLatency(RL)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_ready(pix_ready), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .cat_in(cat_in), .busy(busy), .done(done), .cat_result(cat_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 40) $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {int addr; int data;} wr_t;
    wr_t         m_q[$];
    bit          m_busy = 0;
    int          m_done_cyc = -1;
    bit          m_res = 0;
    bit          m_res_pend = 0;
    int          m_hs = 0;
    int          pix_writes = 0;
    bit          prev_setup = 0;
    logic [AD:0] prev_addr;
    logic [W-1:0] prev_data;

    always @(negedge clk) begin
        if (rst) begin
            chk("reset_outputs",
                {PSEL, PENABLE, PWRITE, pix_ready, busy, done, cat_result, PADDR, PWDATA}, 64'd0);
            m_q.delete();
            m_busy = 0; m_done_cyc = -1; m_res = 0; m_res_pend = 0;
            m_hs = 0; pix_writes = 0; prev_setup = 0;
        end else begin
            if (cyc == m_done_cyc) m_res = m_res_pend;
            chk("busy", busy, m_busy);
            chk("done", done, cyc == m_done_cyc);
            chk("cat_result", cat_result, m_res);
            if (pix_ready) chk("ready_legal", !PSEL && m_busy, 1);
            if (PENABLE) chk("penable_with_psel", PSEL, 1);
            if (PSEL) chk("pwrite", PWRITE, 1);

            if (PSEL && !PENABLE) begin
                chk("setup_after_idle", prev_setup, 0);
                prev_addr = PADDR;
                prev_data = PWDATA;
            end else if (PSEL && PENABLE) begin
                chk("access_after_setup", prev_setup, 1);
                chk("addr_stable", PADDR, prev_addr);
                chk("data_stable", PWDATA, prev_data);
                if (m_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_write: addr %0d data %0d with nothing queued", PADDR, PWDATA);
                end else begin
                    wr_t w;
                    w = m_q.pop_front();
                    chk("wr_addr", PADDR, w.addr);
                    chk("wr_data", PWDATA, w.data);
                    if (w.addr != 0) pix_writes++;
                    else m_done_cyc = cyc + RL + 1;
                end
            end else if (prev_setup) begin
                chk("setup_followed_by_access", 0, 1'b1 & prev_setup);
            end
            prev_setup = PSEL && !PENABLE;

            if (pix_valid && pix_ready) begin
                m_hs++;
                chk("handshake_bound", m_hs <= N, 1);
                m_q.push_back('{addr: m_hs, data: int'(pix_data)});
                if (m_hs == N) m_q.push_back('{addr: 0, data: 1});
            end

            if (cyc == m_done_cyc - 1) begin
                m_res_pend = cat_in;
                m_busy = 0;
            end else if (!m_busy && start && cyc != m_done_cyc) begin
                m_busy = 1; m_hs = 0; pix_writes = 0;
                m_q.delete();
            end
        end
    end

    // ---------------- stimulus ----------------
    // mode 0: pix_valid held, stray start at word 100 and on the done cycle
    // mode 1: random stalls plus a 5-cycle gap before word 10
    // mode 2: reset in ACCESS of word 2000
    // mode 3: pix_valid held
    task automatic run_frame(input int mode, input bit cin, output int st_c, output int dn_c);
        int gap_left; bit in_gap, gap_done, pulsed, finished; int acc_n;
        gap_left = 0; gap_done = 0; pulsed = 0; finished = 0; acc_n = 0; dn_c = -1;
        @(posedge clk); #1;
        start = 1; pix_valid = 1; pix_data = W'($urandom); cat_in = ~cin;
        @(negedge clk);
        st_c = cyc;
        for (int i = 0; i < 30000 && !finished; i++) begin
            @(posedge clk); #1;
            start = 0;
            if (mode == 0 && !pulsed && m_hs == 100) begin start = 1; pulsed = 1; end
            if (mode == 0 && cyc == st_c + LAT) start = 1;
            if (mode == 1 && !gap_done && m_hs == 9) begin gap_left = 7; gap_done = 1; end
            in_gap = 0;
            if (gap_left > 0) begin in_gap = 1; gap_left--; pix_valid = 0; end
            else if (mode == 1) pix_valid = ($urandom_range(7) != 0);
            else pix_valid = 1;
            pix_data = W'($urandom);
            cat_in = (cyc == m_done_cyc - 1) ? cin : ~cin;
            @(negedge clk);
            if (in_gap && gap_left <= 4) begin
                chk("gap_psel", PSEL, 0);
                chk("gap_ready", pix_ready, 1);
            end
            if (PSEL && PENABLE) begin
                acc_n++;
                if (acc_n == 1)  chk("first_addr", PADDR, 1);
                if (acc_n == 10) chk("word10_addr", PADDR, 10);
                if (acc_n == N + 1) begin
                    chk("start_reg_addr", PADDR, 0);
                    chk("start_reg_data", PWDATA, 1);
                end
                if (mode == 2 && acc_n == 2000) begin
                    #1 rst = 1;
                    #1;
                    chk("rst_psel", PSEL, 0);
                    chk("rst_penable", PENABLE, 0);
                    chk("rst_busy", busy, 0);
                    @(posedge clk); #1;
                    @(posedge clk); #1;
                    rst = 0; start = 0; pix_valid = 0;
                    finished = 1;
                end
            end
            if (!finished && done) begin dn_c = cyc; finished = 1; end
        end
        if (!finished) begin
            tests++; fails++;
            $display("FAIL frame_timeout: mode %0d no done within budget", mode);
        end
    endtask

    int st, dn;

    initial begin
        rst = 1; start = 0; pix_valid = 0; pix_data = '0; cat_in = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;

        run_frame(0, 1'b1, st, dn);
        chk("A_latency", dn - st, LAT);
        chk("A_result", cat_result, 1);
        chk("A_pix_writes", pix_writes, N);

        run_frame(1, 1'b0, st, dn);
        chk("B_result", cat_result, 0);
        chk("B_pix_writes", pix_writes, N);

        repeat (20) @(negedge clk);
        chk("idle_hold_result", cat_result, 0);
        chk("idle_busy", busy, 0);

        run_frame(2, 1'b1, st, dn);

        run_frame(3, 1'b1, st, dn);
        chk("D_latency", dn - st, LAT);
        chk("D_result", cat_result, 1);
        chk("D_pix_writes", pix_writes, N);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
